// File: rtl/urp_pcie_tx_credit_arbiter.sv
// rtl/urp_pcie_tx_credit_arbiter.sv - credit-gated round-robin TLP scheduler for the PCIe TX link
module urp_pcie_tx_credit_arbiter #(
  parameter int N_SRC            = 2,
  parameter int DATA_WIDTH       = 224,
  parameter int CREDIT_W         = 8,
  parameter int INIT_HDR_CREDIT  = 8,
  parameter int INIT_DATA_CREDIT = 8,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            src_valid_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic [N_SRC-1:0]            src_ready_o,
  output logic                        dst_valid_o,
  output logic [DATA_WIDTH-1:0]       dst_data_o,
  input  logic                        dst_ready_i,
  input  logic                        fc_init_i,
  input  logic                        crd_ret_valid_i,
  input  logic [SRC_W-1:0]            crd_ret_src_i,
  input  logic [CREDIT_W-1:0]         crd_ret_hdr_i,
  input  logic [CREDIT_W-1:0]         crd_ret_data_i,
  output logic                        fc_ready_o
);

  typedef enum logic [1:0] {FC_INIT, ARB, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] hdr_cnt  [N_SRC];
  logic [CREDIT_W-1:0] data_cnt [N_SRC];
  logic [CREDIT_W-1:0] hdr_nxt  [N_SRC];
  logic [CREDIT_W-1:0] data_nxt [N_SRC];
  logic [SRC_W-1:0]    last_grant;
  logic [N_SRC-1:0]    data_cost;
  logic [N_SRC-1:0]    eligible;
  logic                grant_found;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant;
  int                  cand;
  logic [CREDIT_W-1:0] ret_hdr, ret_data;
  logic                consume;
  logic [CREDIT_W:0]   hdr_sum, data_sum;

  // Eligibility: fmt[1] marks a TLP carrying one data credit's worth of payload
  always_comb begin
    data_cost = '0;
    eligible  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      data_cost[k] = src_data_i[k*DATA_WIDTH + DATA_WIDTH - 2];
      eligible[k]  = src_valid_i[k] && (hdr_cnt[k] != '0) &&
                     (data_cnt[k] >= CREDIT_W'(data_cost[k]));
    end
  end

  // Round-robin search starting just after the most recent grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = (int'(last_grant) + i) % N_SRC;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    src_ready_o = '0;
    fc_ready_o  = 1'b0;
    dst_valid_o = 1'b0;
    case (state_q)
      FC_INIT: begin
        if (fc_init_i) state_d = ARB;
      end
      ARB: begin
        fc_ready_o = 1'b1;
        if (grant_found) begin
          grant       = 1'b1;
          src_ready_o = N_SRC'(1) << grant_idx;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        fc_ready_o  = 1'b1;
        dst_valid_o = 1'b1;
        if (dst_ready_i) state_d = ARB;
      end
      default: state_d = FC_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FC_INIT;
    else        state_q <= state_d;
  end

  // Capture the granted TLP and remember who won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_data_o <= '0;
      last_grant <= SRC_W'(N_SRC - 1);
    end else if (grant) begin
      dst_data_o <= src_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      last_grant <= grant_idx;
    end
  end

  // Credit next value: consume and return in one step, saturating, init overrides
  always_comb begin
    ret_hdr  = '0;
    ret_data = '0;
    consume  = 1'b0;
    hdr_sum  = '0;
    data_sum = '0;
    for (int k = 0; k < N_SRC; k++) begin
      consume  = grant && (grant_idx == SRC_W'(k));
      ret_hdr  = (crd_ret_valid_i && crd_ret_src_i == SRC_W'(k)) ? crd_ret_hdr_i  : '0;
      ret_data = (crd_ret_valid_i && crd_ret_src_i == SRC_W'(k)) ? crd_ret_data_i : '0;
      hdr_sum  = {1'b0, hdr_cnt[k]} + {1'b0, ret_hdr} - (CREDIT_W+1)'(consume);
      data_sum = {1'b0, data_cnt[k]} + {1'b0, ret_data} -
                 (CREDIT_W+1)'(consume && data_cost[k]);
      hdr_nxt[k]  = hdr_sum[CREDIT_W]  ? '1 : hdr_sum[CREDIT_W-1:0];
      data_nxt[k] = data_sum[CREDIT_W] ? '1 : data_sum[CREDIT_W-1:0];
      if (fc_init_i) begin
        hdr_nxt[k]  = CREDIT_W'(INIT_HDR_CREDIT);
        data_nxt[k] = CREDIT_W'(INIT_DATA_CREDIT);
      end
    end
  end

  // Credit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SRC; k++) begin
        hdr_cnt[k]  <= '0;
        data_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        hdr_cnt[k]  <= hdr_nxt[k];
        data_cnt[k] <= data_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_urp_pcie_tx_credit_arbiter.sv
// tb/tb_urp_pcie_tx_credit_arbiter.sv - self-checking bench for the TX credit arbiter
module tb_urp_pcie_tx_credit_arbiter;
  localparam int DW = 224;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    src_valid;
  logic [2*DW-1:0] src_data;
  logic [1:0]    src_ready;
  logic          dst_valid;
  logic [DW-1:0] dst_data;
  logic          dst_ready;
  logic          fc_init;
  logic          crd_ret_valid;
  logic [0:0]    crd_ret_src;
  logic [7:0]    crd_ret_hdr, crd_ret_data;
  logic          fc_ready;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] tlp [2];

  urp_pcie_tx_credit_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
    .dst_valid_o(dst_valid), .dst_data_o(dst_data), .dst_ready_i(dst_ready),
    .fc_init_i(fc_init), .crd_ret_valid_i(crd_ret_valid), .crd_ret_src_i(crd_ret_src),
    .crd_ret_hdr_i(crd_ret_hdr), .crd_ret_data_i(crd_ret_data), .fc_ready_o(fc_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] make_tlp(input logic [2:0] fmt);
    logic [DW-1:0] t;
    t = '0;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    t[DW-1 -: 3] = fmt;
    return t;
  endfunction

  task automatic set_src(input int k, input logic [2:0] fmt);
    tlp[k] = make_tlp(fmt);
    src_data[k*DW +: DW] = tlp[k];
  endtask

  task automatic clear_ret();
    crd_ret_valid = 1'b0; crd_ret_src = '0; crd_ret_hdr = '0; crd_ret_data = '0;
  endtask

  task automatic pulse_init();
    fc_init = 1'b1;
    tick();
    fc_init = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_valid = '0; src_data = '0; dst_ready = 1'b1; fc_init = 1'b0;
    clear_ret();
    #2;
    checks++;
    if (dst_valid !== 1'b0 || dst_data !== '0 || src_ready !== 2'b00 || fc_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dv=%b dd_zero=%b sr=%b fr=%b, need 0/1/00/0",
               dst_valid, dst_data == '0, src_ready, fc_ready);
    end
    checks++;
    if (dut.hdr_cnt[0] !== 8'd0 || dut.data_cnt[1] !== 8'd0) begin
      errors++;
      $display("FAIL reset_counters: hdr0=%0d data1=%0d, need 0/0", dut.hdr_cnt[0], dut.data_cnt[1]);
    end
    tick(); tick();
    rst_n = 1'b1;
    set_src(0, 3'b010); set_src(1, 3'b010);
    src_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      #2;
      checks++;
      if (src_ready !== 2'b00 || dst_valid !== 1'b0 || fc_ready !== 1'b0) begin
        errors++;
        $display("FAIL no_init_idle: cyc=%0d sr=%b dv=%b fr=%b, need 00/0/0", c, src_ready, dst_valid, fc_ready);
      end
      tick();
    end
    src_valid = '0;
  endtask

  task automatic test_alternate();
    int ngrant;
    int last_k;
    ngrant = 0; last_k = -1;
    pulse_init();
    #2;
    checks++;
    if (fc_ready !== 1'b1 || dut.hdr_cnt[1] !== 8'd8 || dut.data_cnt[0] !== 8'd8) begin
      errors++;
      $display("FAIL init_load: fr=%b hdr1=%0d data0=%0d, need 1/8/8", fc_ready, dut.hdr_cnt[1], dut.data_cnt[0]);
    end
    set_src(0, 3'b010); set_src(1, 3'b010);
    src_valid = 2'b11; dst_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (dst_valid === 1'b1 && last_k >= 0) begin
        checks++;
        if (dst_data !== tlp[last_k]) begin
          errors++;
          $display("FAIL alt_data: src=%0d got %h need %h", last_k, dst_data[31:0], tlp[last_k][31:0]);
        end
      end
      if (src_ready !== 2'b00) begin
        checks++;
        if (src_ready !== (2'b01 << (ngrant % 2))) begin
          errors++;
          $display("FAIL alt_order: grant#%0d sr=%b need %b", ngrant, src_ready, 2'b01 << (ngrant % 2));
        end
        last_k = src_ready[1] ? 1 : 0;
        ngrant++;
      end
      tick();
    end
    checks++;
    if (ngrant !== 16) begin
      errors++;
      $display("FAIL alt_count: got %0d grants need 16", ngrant);
    end
    checks++;
    if (dut.hdr_cnt[0] !== 8'd0 || dut.data_cnt[0] !== 8'd0 || dut.hdr_cnt[1] !== 8'd0 || dut.data_cnt[1] !== 8'd0) begin
      errors++;
      $display("FAIL alt_drained: h0=%0d d0=%0d h1=%0d d1=%0d need all 0",
               dut.hdr_cnt[0], dut.data_cnt[0], dut.hdr_cnt[1], dut.data_cnt[1]);
    end
    src_valid = '0;
  endtask

  task automatic test_starve();
    int g1;
    g1 = 0;
    crd_ret_valid = 1'b1; crd_ret_src = 1'b0; crd_ret_hdr = 8'd4; crd_ret_data = 8'd0;
    tick();
    crd_ret_src = 1'b1; crd_ret_hdr = 8'd3;
    tick();
    clear_ret();
    set_src(0, 3'b010); set_src(1, 3'b000);
    src_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (src_ready[0] === 1'b1) begin
        checks++; errors++;
        $display("FAIL starve_src0: starved source granted at cyc %0d", c);
      end
      if (src_ready[1] === 1'b1) g1++;
      tick();
    end
    checks++;
    if (g1 !== 3) begin
      errors++;
      $display("FAIL starve_src1_count: got %0d need 3", g1);
    end
    crd_ret_valid = 1'b1; crd_ret_src = 1'b0; crd_ret_data = 8'd2;
    #2;
    checks++;
    if (src_ready !== 2'b00) begin
      errors++;
      $display("FAIL starve_ret_cycle: sr=%b need 00", src_ready);
    end
    tick();
    clear_ret();
    #2;
    checks++;
    if (src_ready !== 2'b01) begin
      errors++;
      $display("FAIL starve_unblock: sr=%b need 01", src_ready);
    end
    tick();
    src_valid = '0;
    #2;
    checks++;
    if (dst_valid !== 1'b1 || dst_data !== tlp[0]) begin
      errors++;
      $display("FAIL starve_data: dv=%b got %h need %h", dst_valid, dst_data[31:0], tlp[0][31:0]);
    end
    tick();
  endtask

  task automatic test_hold_stall();
    pulse_init();
    dst_ready = 1'b0;
    set_src(0, 3'b010); set_src(1, 3'b000);
    src_valid = 2'b01;
    #2;
    checks++;
    if (src_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_grant: sr=%b need 01", src_ready);
    end
    tick();
    src_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if (dst_valid !== 1'b1 || dst_data !== tlp[0] || src_ready !== 2'b00 ||
          dut.hdr_cnt[0] !== 8'd7 || dut.data_cnt[0] !== 8'd7) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d dv=%b data_ok=%b sr=%b h0=%0d d0=%0d need 1/1/00/7/7",
                 c, dst_valid, dst_data == tlp[0], src_ready, dut.hdr_cnt[0], dut.data_cnt[0]);
      end
      tick();
    end
    dst_ready = 1'b1;
    #2;
    checks++;
    if (dst_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_handshake: dv=%b need 1", dst_valid);
    end
    tick();
    #2;
    checks++;
    if (src_ready !== 2'b10) begin
      errors++;
      $display("FAIL stall_back_to_arb: sr=%b need 10", src_ready);
    end
    src_valid = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    pulse_init();
    set_src(0, 3'b010);
    src_valid = 2'b01; dst_ready = 1'b1;
    crd_ret_valid = 1'b1; crd_ret_src = 1'b0; crd_ret_hdr = 8'd3; crd_ret_data = 8'd0;
    #2;
    checks++;
    if (src_ready !== 2'b01) begin
      errors++;
      $display("FAIL simul_grant: sr=%b need 01", src_ready);
    end
    tick();
    clear_ret(); src_valid = '0;
    #2;
    checks++;
    if (dut.hdr_cnt[0] !== 8'd10 || dut.data_cnt[0] !== 8'd7) begin
      errors++;
      $display("FAIL simul_counts: hdr=%0d data=%0d need 10/7", dut.hdr_cnt[0], dut.data_cnt[0]);
    end
    tick();
  endtask

  task automatic test_saturate();
    pulse_init();
    crd_ret_valid = 1'b1; crd_ret_src = 1'b0; crd_ret_hdr = 8'd255; crd_ret_data = 8'd0;
    tick();
    crd_ret_src = 1'b1; crd_ret_data = 8'd255;
    tick();
    clear_ret();
    #2;
    checks++;
    if (dut.hdr_cnt[0] !== 8'd255 || dut.data_cnt[0] !== 8'd8) begin
      errors++;
      $display("FAIL sat_src0: hdr=%0d data=%0d need 255/8", dut.hdr_cnt[0], dut.data_cnt[0]);
    end
    checks++;
    if (dut.hdr_cnt[1] !== 8'd255 || dut.data_cnt[1] !== 8'd255) begin
      errors++;
      $display("FAIL sat_src1: hdr=%0d data=%0d need 255/255", dut.hdr_cnt[1], dut.data_cnt[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    pulse_init();
    dst_ready = 1'b0;
    set_src(1, 3'b000);
    src_valid = 2'b10;
    tick();
    src_valid = '0;
    #2;
    checks++;
    if (dst_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_setup: dv=%b need 1", dst_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dst_valid !== 1'b0 || fc_ready !== 1'b0 || dst_data !== '0) begin
      errors++;
      $display("FAIL rst_hold_clear: dv=%b fr=%b dd_zero=%b need 0/0/1", dst_valid, fc_ready, dst_data == '0);
    end
    tick();
    rst_n = 1'b1; dst_ready = 1'b1;
    set_src(0, 3'b010); set_src(1, 3'b000);
    src_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if (src_ready !== 2'b00 || fc_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_grant: cyc=%0d sr=%b fr=%b need 00/0", c, src_ready, fc_ready);
      end
      tick();
    end
    pulse_init();
    #2;
    checks++;
    if (src_ready !== 2'b01 || fc_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_grant: sr=%b fr=%b need 01/1", src_ready, fc_ready);
    end
    src_valid = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    int m_hdr [2];
    int m_dat [2];
    int m_last, g, c, v, cost;
    bit m_ready, m_busy;
    logic [DW-1:0] m_data;
    logic [1:0] exp_sr;
    rst_n = 1'b0; src_valid = '0; fc_init = 1'b0; clear_ret();
    tick();
    rst_n = 1'b1;
    m_hdr = '{0, 0}; m_dat = '{0, 0};
    m_last = 1; m_ready = 0; m_busy = 0; m_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      src_valid = 2'($urandom);
      for (int k = 0; k < 2; k++) set_src(k, {1'b0, 1'($urandom), 1'b0});
      dst_ready = ($urandom_range(0, 9) < 7);
      fc_init = (cyc == 0) || ($urandom_range(0, 99) == 0);
      crd_ret_valid = ($urandom_range(0, 4) == 0);
      crd_ret_src = 1'($urandom);
      crd_ret_hdr = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      crd_ret_data = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      #2;
      g = -1;
      if (m_ready && !m_busy) begin
        for (int i = 1; i <= 2; i++) begin
          c = (m_last + i) % 2;
          cost = tlp[c][DW-2] ? 1 : 0;
          if (g < 0 && src_valid[c] && m_hdr[c] >= 1 && m_dat[c] >= cost) g = c;
        end
      end
      exp_sr = (g >= 0) ? (2'b01 << g) : 2'b00;
      checks++;
      if (src_ready !== exp_sr || dst_valid !== m_busy || fc_ready !== m_ready) begin
        errors++;
        $display("FAIL rand_ctrl: cyc=%0d sr=%b dv=%b fr=%b need %b/%b/%b",
                 cyc, src_ready, dst_valid, fc_ready, exp_sr, m_busy, m_ready);
      end
      if (m_busy) begin
        checks++;
        if (dst_data !== m_data) begin
          errors++;
          $display("FAIL rand_data: cyc=%0d got %h need %h", cyc, dst_data[31:0], m_data[31:0]);
        end
      end
      if (m_busy && dst_ready) m_busy = 0;
      for (int k = 0; k < 2; k++) begin
        if (fc_init) begin
          m_hdr[k] = 8; m_dat[k] = 8;
        end else begin
          v = m_hdr[k] - ((g == k) ? 1 : 0) +
              ((crd_ret_valid && crd_ret_src == k) ? int'(crd_ret_hdr) : 0);
          m_hdr[k] = (v > 255) ? 255 : v;
          v = m_dat[k] - ((g == k && tlp[k][DW-2]) ? 1 : 0) +
              ((crd_ret_valid && crd_ret_src == k) ? int'(crd_ret_data) : 0);
          m_dat[k] = (v > 255) ? 255 : v;
        end
      end
      if (g >= 0) begin
        m_busy = 1; m_data = tlp[g]; m_last = g;
      end
      if (fc_init) m_ready = 1;
      tick();
    end
    src_valid = '0; fc_init = 1'b0; clear_ret();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_starve();
    test_hold_stall();
    test_simultaneous();
    test_saturate();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/urp_pcie_tx_credit_arbiter.md
# urp_pcie_tx_credit_arbiter

Credit-gated round-robin scheduler in front of the PCIe TX link interface. It accepts complete 224-bit TLPs from up to N_SRC transaction-layer requesters, such as memory-request and completion queues. A TLP is granted only when its source holds enough header and data flow-control credits. The granted TLP is presented on a single valid/ready output port, and credits returned by the link partner are tracked per source.

## Interface
Parameters:
- N_SRC, 2: number of requesters (≥2).
- DATA_WIDTH, 224: TLP width. Bits [DATA_WIDTH-1 -: 3] are the fmt field.
- CREDIT_W, 8: width of each credit counter.
- INIT_HDR_CREDIT, 8: header credits loaded per source on fc_init_i.
- INIT_DATA_CREDIT, 8: data credits loaded per source on fc_init_i.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- src_valid_i, in, N_SRC: bit k means source k presents a TLP.
- src_data_i, in, N_SRC*DATA_WIDTH: TLP of source k at [k*DATA_WIDTH +: DATA_WIDTH].
- src_ready_o, out, N_SRC: one-hot, one-cycle acceptance of the granted source's TLP.
- dst_valid_o, out, 1: output TLP valid.
- dst_data_o, out, DATA_WIDTH: output TLP.
- dst_ready_i, in, 1: downstream accepts the TLP.
- fc_init_i, in, 1: pulse that loads all credit counters with their INIT values.
- crd_ret_valid_i, in, 1: credit return strobe.
- crd_ret_src_i, in, $clog2(N_SRC): source receiving the returned credits.
- crd_ret_hdr_i, in, CREDIT_W: header credits returned.
- crd_ret_data_i, in, CREDIT_W: data credits returned.
- fc_ready_o, out, 1: high once flow control has been initialised.

## Operation
- States:
  - FC_INIT (reset state): no grants; fc_ready_o=0.
  - ARB: fc_ready_o=1.
  - HOLD: fc_ready_o=1.
- State transitions:
  - FC_INIT→ARB on fc_init_i.
  - ARB→HOLD on a grant.
  - HOLD→ARB on dst_valid_o && dst_ready_i.
- TLP cost: header cost is always 1. Data cost is 1 if fmt[1]=1 (TLP with data, one 128-bit payload), else 0.
- Source k is eligible when src_valid_i[k], hdr_cnt[k]≥1, and data_cnt[k]≥data cost.
- ARB grant selection:
  - Round-robin, searching from (last_grant+1) mod N_SRC upward with wrap; last_grant resets to N_SRC-1.
  - On a grant: src_ready_o[k]=1 combinationally in that cycle; src_data_i slice k is registered into dst_data_o; both counters of source k are decremented by the cost; last_grant←k.
  - No eligible source means no grant, and the scheduler stays in ARB.
- HOLD:
  - dst_valid_o=1; dst_data_o is held stable until the handshake.
  - src_ready_o=0.
- Credit update per source, every cycle: cnt_next = cnt − consumed + returned, applied in one step so a simultaneous consume and return on the same source are both honoured.
- Credit saturation:
  - Sums saturate at 2^CREDIT_W−1.
  - Underflow cannot occur because of the eligibility rule.
  - A return to an out-of-range crd_ret_src_i is ignored.
- fc_init_i in ARB or HOLD:
  - Reloads all counters to their INIT values.
  - Overrides any consume or return in that cycle.
  - An in-flight HOLD TLP still completes.
- A source that drops src_valid_i before it is granted is simply not considered.

## Timing
- Reset values:
  - dst_valid_o=0, dst_data_o=0, src_ready_o=0, fc_ready_o=0.
  - All credit counters=0; state=FC_INIT.
- fc_init_i sampled at edge t: fc_ready_o=1 and counters loaded from t+1, so the first grant is possible in cycle t+1.
- Grant latency: src_ready_o rises in the same cycle the eligible source is seen in ARB. dst_valid_o rises the next cycle.
- Throughput: at most 1 TLP per 2 cycles (ARB then HOLD), assuming dst_ready_i is held high.
- A credit return at edge t is visible to eligibility in cycle t+1.
- Reset asserted mid-operation: everything clears immediately, including the HOLD TLP. The scheduler then requires a new fc_init_i before any further grants.

## Test plan
- Reset, then hold src_valid_i=2'b11 with no fc_init_i for 20 cycles -> src_ready_o=0, dst_valid_o=0, fc_ready_o=0 throughout.
- Pulse fc_init_i, then both sources valid continuously with fmt=3'b010 and dst_ready_i=1:
  - Grants alternate 0,1,0,1.
  - After 8 grants per source, grants stop with hdr_cnt=0 and data_cnt=0.
- Starve source 0 (data_cnt=0, fmt=3'b010); source 1 sends fmt=3'b000 TLPs -> only source 1 is granted. Then return crd_ret_data_i=2 to source 0 -> source 0 is granted on the cycle after the return.
- Hold dst_ready_i=0 for 5 cycles during HOLD -> dst_data_o stays constant, src_ready_o=0, no counter change; the handshake on cycle 6 returns to ARB.
- Same cycle on source 0: grant of a fmt=3'b010 TLP with hdr=8/data=8, plus a return of hdr=3/data=0 -> next counters are hdr=10, data=7.
- Return 255 header credits on top of 8 with CREDIT_W=8 -> counter saturates at 255.
- Assert rst_n=0 while in HOLD -> dst_valid_o drops immediately and fc_ready_o=0; after deassertion no grants until fc_init_i.
